// File: rtl/comp_case.sv
// Latch-free 3:1 one-bit selector with a registered copy of the selected value.
// Select codes 10 and 11 both pick i2, so every code has a defined output.
module comp_case (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  output logic       y,
  output logic       y_q
);

  // Default assignment first keeps the y path pure gates for any sel value.
  always_comb begin
    y = i2;
    case (sel)
      2'b00:   y = i0;
      2'b01:   y = i1;
      default: y = i2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) y_q <= 1'b0;
    else       y_q <= y;
  end

endmodule

// File: tb/tb_comp_case.sv
// Directed self-checking bench for comp_case: select sweep, free-running latch check,
// reset behaviour and the one-cycle y_q pipeline.
`timescale 1ns/1ps
module tb_comp_case;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sel = 2'b00;
  logic       i0 = 1'b0;
  logic       i1 = 1'b0;
  logic       i2 = 1'b0;
  logic       y;
  logic       y_q;

  int n_cmp = 0;
  int n_err = 0;

  comp_case dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .y     (y),
    .y_q   (y_q)
  );

  always #5 clk = ~clk;

  // Reference select written as a priority tree rather than a case statement.
  function automatic logic ref_y(input logic [1:0] s, input logic a, input logic b, input logic c);
    return s[1] ? c : (s[0] ? b : a);
  endfunction

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; sel = 2'b00; i0 = 1'b1; i1 = 1'b0; i2 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (y_q !== 1'b0) begin n_err++; $display("FAIL reset_yq got=%b want=0", y_q); end
    n_cmp++;
    if (y !== 1'b1) begin n_err++; $display("FAIL reset_y got=%b want=1", y); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (y_q !== 1'b1) begin n_err++; $display("FAIL release_yq got=%b want=1", y_q); end
  endtask

  task automatic test_static_sweep;
    logic [1:0] sv [8]  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
    logic [2:0] iv [8]  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100};
    logic       ev [8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sel = sv[k]; {i2, i1, i0} = iv[k];
      #1;
      n_cmp++;
      if (y !== ev[k]) begin
        n_err++;
        $display("FAIL sweep_%0d sel=%b i=%b got=%b want=%b", k, sv[k], iv[k], y, ev[k]);
      end
    end
  endtask

  // Free-running inputs: i0 period 634, i1 period 74, i2 period 114, sel steps every 1200.
  task automatic test_latch;
    int errs_here = 0;
    for (int t = 0; t < 5000; t += 2) begin
      i0  = ((t / 317) % 2) == 1;
      i1  = ((t / 37) % 2) == 1;
      i2  = ((t / 57) % 2) == 1;
      sel = 2'((t / 1200) % 4);
      #1;
      n_cmp++;
      if (y !== ref_y(sel, i0, i1, i2)) begin
        n_err++;
        if (errs_here < 10)
          $display("FAIL latch t=%0d sel=%b i=%b%b%b got=%b want=%b",
                   t, sel, i2, i1, i0, y, ref_y(sel, i0, i1, i2));
        errs_here++;
      end
      #1;
    end
  endtask

  task automatic test_reset_hold;
    @(negedge clk);
    reset = 1'b0; sel = 2'b00; i0 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (y_q !== 1'b1) begin n_err++; $display("FAIL hold_pre_yq got=%b want=1", y_q); end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (y_q !== 1'b0) begin n_err++; $display("FAIL hold_yq_%0d got=%b want=0", k, y_q); end
      i0 = ~i0;
      #1;
      n_cmp++;
      if (y !== i0) begin n_err++; $display("FAIL hold_y_%0d got=%b want=%b", k, y, i0); end
    end
    i0 = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (y_q !== 1'b1) begin n_err++; $display("FAIL hold_release_yq got=%b want=1", y_q); end
  endtask

  task automatic test_pipeline;
    @(negedge clk);
    sel = 2'b01; i1 = 1'b0; i0 = 1'b1; i2 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (y_q !== 1'b0) begin n_err++; $display("FAIL pipe_pre_yq got=%b want=0", y_q); end
    i1 = 1'b1;
    #1;
    n_cmp++;
    if (y !== 1'b1) begin n_err++; $display("FAIL pipe_y got=%b want=1", y); end
    n_cmp++;
    if (y_q !== 1'b0) begin n_err++; $display("FAIL pipe_yq_early got=%b want=0", y_q); end
    @(negedge clk);
    n_cmp++;
    if (y_q !== 1'b1) begin n_err++; $display("FAIL pipe_yq got=%b want=1", y_q); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] sv [6] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01};
    logic [2:0] iv [6] = '{3'b110, 3'b100, 3'b010, 3'b011, 3'b001, 3'b101};
    logic       ev [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sel = sv[k]; {i2, i1, i0} = iv[k];
      @(negedge clk);
      n_cmp++;
      if (y_q !== ev[k]) begin
        n_err++;
        $display("FAIL b2b_%0d sel=%b i=%b got=%b want=%b", k, sv[k], iv[k], y_q, ev[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_static_sweep;
    test_latch;
    test_reset_hold;
    test_pipeline;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
